// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the clock-set controller and the
// time counters, buttons and tick generators around it.
interface clock_set_ctrl_if;
   logic       TICK_1HZ;
   logic       TICK_FAST;
   logic       BTN_MODE;
   logic       BTN_INC;
   logic       SecMax;
   logic       MinMax;
   logic       EN_Sec;
   logic       EN_Min;
   logic       EN_Hr;
   logic       nCR_Sec;
   logic [1:0] Mode;
   logic       Blink;

   modport master (
      output TICK_1HZ, TICK_FAST, BTN_MODE, BTN_INC, SecMax, MinMax,
      input  EN_Sec, EN_Min, EN_Hr, nCR_Sec, Mode, Blink
   );

   modport slave (
      input  TICK_1HZ, TICK_FAST, BTN_MODE, BTN_INC, SecMax, MinMax,
      output EN_Sec, EN_Min, EN_Hr, nCR_Sec, Mode, Blink
   );
endinterface

// File: rtl/clock_set_ctrl.sv
// Run/set-hour/set-minute controller for a 24h clock:
// count enables, auto-repeat, set timeout and field blink.
module clock_set_ctrl #(
   parameter int RPT_DLY   = 4,
   parameter int TIMEOUT   = 30,
   parameter int BLINK_DIV = 4
) (
   input logic             CP,
   input logic             CR,
   clock_set_ctrl_if.slave bus
);

   localparam logic [3:0] RPT_LIM = 4'(RPT_DLY);
   localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);
   localparam logic [3:0] BL_LAST = 4'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   state_t     state;
   state_t     nxt;

   logic       mode_q;
   logic       inc_q;
   logic [3:0] rpt_cnt;
   logic [5:0] to_cnt;
   logic [3:0] bl_cnt;
   logic       phase;

   logic       en_sec;
   logic       en_min;
   logic       en_hr;
   logic       ncr_sec;
   logic       blink;

   logic       mode_edge;
   logic       inc_edge;
   logic       in_set;
   logic       timeout;
   logic       rpt_step;
   logic       inc_step;
   logic       bl_wrap;
   logic       ph_nxt;
   logic       leave_min;
   logic       tick_run;

   always_comb begin
      mode_edge = bus.BTN_MODE & ~mode_q;
      inc_edge  = bus.BTN_INC & ~inc_q;
      in_set    = (state == SET_HR) || (state == SET_MIN);
      timeout   = in_set && bus.TICK_1HZ
                  && (to_cnt == TO_LAST);
      rpt_step  = bus.BTN_INC && !inc_edge
                  && bus.TICK_FAST
                  && (rpt_cnt == RPT_LIM);
      // a mode change or timeout swallows a coincident INC step
      inc_step  = in_set && (inc_edge || rpt_step)
                  && !mode_edge && !timeout;
      bl_wrap   = bus.TICK_FAST && (bl_cnt == BL_LAST);
      ph_nxt    = bl_wrap ? ~phase : phase;
      tick_run  = (state == RUN) && bus.TICK_1HZ;

      nxt = state;
      unique case (state)
         RUN: begin
            if (mode_edge) nxt = SET_HR;
         end
         SET_HR: begin
            if (timeout)        nxt = RUN;
            else if (mode_edge) nxt = SET_MIN;
         end
         SET_MIN: begin
            if (timeout || mode_edge) nxt = RUN;
         end
         ILLEGAL: begin
            nxt = RUN;
         end
      endcase

      leave_min = (state == SET_MIN) && (nxt == RUN);
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         state   <= RUN;
         mode_q  <= 1'b0;
         inc_q   <= 1'b0;
         rpt_cnt <= '0;
         to_cnt  <= '0;
         bl_cnt  <= '0;
         phase   <= 1'b1;
         en_sec  <= 1'b0;
         en_min  <= 1'b0;
         en_hr   <= 1'b0;
         ncr_sec <= 1'b1;
         blink   <= 1'b1;
      end else begin
         state  <= nxt;
         mode_q <= bus.BTN_MODE;
         inc_q  <= bus.BTN_INC;

         if (inc_edge || !bus.BTN_INC)
            rpt_cnt <= '0;
         else if (bus.TICK_FAST && (rpt_cnt != RPT_LIM))
            rpt_cnt <= rpt_cnt + 4'd1;

         if ((nxt == RUN) || (nxt != state)
             || mode_edge || inc_edge)
            to_cnt <= '0;
         else if (bus.TICK_1HZ)
            to_cnt <= to_cnt + 6'd1;

         en_sec <= tick_run;
         en_min <= (tick_run && bus.SecMax)
                   || ((state == SET_MIN) && inc_step);
         en_hr  <= (tick_run && bus.SecMax && bus.MinMax)
                   || ((state == SET_HR) && inc_step);

         ncr_sec <= ~leave_min;

         // each set-mode entry restarts the blink phase visible
         if ((nxt == RUN) || (nxt != state)) begin
            bl_cnt <= '0;
            phase  <= 1'b1;
            blink  <= 1'b1;
         end else begin
            phase  <= ph_nxt;
            blink  <= inc_step | ph_nxt;
            if (bl_wrap)
               bl_cnt <= '0;
            else if (bus.TICK_FAST)
               bl_cnt <= bl_cnt + 4'd1;
         end
      end
   end

   assign bus.EN_Sec  = en_sec;
   assign bus.EN_Min  = en_min;
   assign bus.EN_Hr   = en_hr;
   assign bus.nCR_Sec = ncr_sec;
   assign bus.Mode    = state;
   assign bus.Blink   = blink;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with default parameters
// (RPT_DLY=4, TIMEOUT=30, BLINK_DIV=4).
module tb_clock_set_ctrl;

   logic CP = 1'b0;
   logic CR = 1'b1;

   clock_set_ctrl_if bus ();

   clock_set_ctrl dut (
      .CP  (CP),
      .CR  (CR),
      .bus (bus)
   );

   always #5 CP = ~CP;

   int errs   = 0;
   int checks = 0;
   int n_sec  = 0;
   int n_min  = 0;
   int n_hr   = 0;
   int n_ncr  = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance to the next falling edge and tally output pulses
   task automatic cyc();
      @(negedge CP);
      n_sec += bus.EN_Sec ? 1 : 0;
      n_min += bus.EN_Min ? 1 : 0;
      n_hr  += bus.EN_Hr ? 1 : 0;
      n_ncr += (bus.nCR_Sec === 1'b0) ? 1 : 0;
   endtask

   task automatic clr();
      n_sec = 0;
      n_min = 0;
      n_hr  = 0;
      n_ncr = 0;
   endtask

   task automatic press_mode();
      bus.BTN_MODE = 1'b1;
      cyc();
      bus.BTN_MODE = 1'b0;
      cyc();
   endtask

   task automatic pulse_fast();
      bus.TICK_FAST = 1'b1;
      cyc();
      bus.TICK_FAST = 1'b0;
      cyc();
   endtask

   task automatic pulse_1hz();
      bus.TICK_1HZ = 1'b1;
      cyc();
      bus.TICK_1HZ = 1'b0;
      cyc();
   endtask

   initial begin
      bus.TICK_1HZ  = 1'b0;
      bus.TICK_FAST = 1'b0;
      bus.BTN_MODE  = 1'b0;
      bus.BTN_INC   = 1'b0;
      bus.SecMax    = 1'b0;
      bus.MinMax    = 1'b0;
      repeat (3) cyc();

      chk("rst_mode", bus.Mode, 0);
      chk("rst_en", {bus.EN_Sec, bus.EN_Min, bus.EN_Hr}, 0);
      chk("rst_ncr", bus.nCR_Sec, 1);
      chk("rst_blink", bus.Blink, 1);

      CR = 1'b0;
      repeat (2) cyc();

      // full carry: all three enables in the same cycle
      bus.SecMax = 1'b1;
      bus.MinMax = 1'b1;
      bus.TICK_1HZ = 1'b1;
      cyc();
      chk("carry_all", {bus.EN_Sec, bus.EN_Min, bus.EN_Hr}, 3'b111);
      bus.TICK_1HZ = 1'b0;
      cyc();
      chk("carry_one_cyc", {bus.EN_Sec, bus.EN_Min, bus.EN_Hr}, 0);

      bus.MinMax = 1'b0;
      bus.TICK_1HZ = 1'b1;
      cyc();
      chk("carry_min", {bus.EN_Sec, bus.EN_Min, bus.EN_Hr}, 3'b110);
      bus.TICK_1HZ = 1'b0;
      cyc();

      bus.SecMax = 1'b0;
      bus.MinMax = 1'b1;
      bus.TICK_1HZ = 1'b1;
      cyc();
      chk("carry_sec", {bus.EN_Sec, bus.EN_Min, bus.EN_Hr}, 3'b100);
      bus.TICK_1HZ = 1'b0;
      bus.MinMax = 1'b0;
      cyc();

      // INC ignored in RUN, even when held through fast ticks
      clr();
      bus.BTN_INC = 1'b1;
      cyc();
      repeat (6) pulse_fast();
      bus.BTN_INC = 1'b0;
      cyc();
      chk("run_inc_ign", n_min + n_hr, 0);
      chk("run_mode", bus.Mode, 0);
      chk("run_blink", bus.Blink, 1);

      // enter SET_HR and step hours
      bus.BTN_MODE = 1'b1;
      cyc();
      chk("sethr_mode", bus.Mode, 1);
      chk("sethr_blink", bus.Blink, 1);
      bus.BTN_MODE = 1'b0;
      cyc();
      clr();
      for (int k = 0; k < 3; k++) begin
         bus.BTN_INC = 1'b1;
         cyc();
         bus.BTN_INC = 1'b0;
         cyc();
         pulse_1hz();
      end
      chk("sethr_hr3", n_hr, 3);
      chk("sethr_nosec", n_sec, 0);
      chk("sethr_nomin", n_min, 0);
      chk("sethr_mode2", bus.Mode, 1);

      // blink half-period of four fast ticks, forced on by a step
      repeat (3) pulse_fast();
      chk("blink_3", bus.Blink, 1);
      pulse_fast();
      chk("blink_4", bus.Blink, 0);
      bus.BTN_INC = 1'b1;
      cyc();
      chk("blink_step_en", bus.EN_Hr, 1);
      chk("blink_step_on", bus.Blink, 1);
      bus.BTN_INC = 1'b0;
      cyc();
      chk("blink_back", bus.Blink, 0);

      // MODE and INC together: mode wins, step dropped
      clr();
      bus.BTN_MODE = 1'b1;
      bus.BTN_INC = 1'b1;
      cyc();
      chk("coinc_mode", bus.Mode, 2);
      chk("coinc_blink", bus.Blink, 1);
      bus.BTN_MODE = 1'b0;
      bus.BTN_INC = 1'b0;
      cyc();
      chk("coinc_nostep", n_hr + n_min, 0);

      // auto-repeat in SET_MIN
      clr();
      bus.BTN_INC = 1'b1;
      cyc();
      chk("rpt_edge", bus.EN_Min, 1);
      for (int i = 0; i < 10; i++) begin
         pulse_fast();
         if (i == 3) chk("rpt_after4", n_min, 1);
         if (i == 4) chk("rpt_after5", n_min, 2);
      end
      bus.BTN_INC = 1'b0;
      cyc();
      chk("rpt_total", n_min, 7);
      chk("rpt_nohr", n_hr, 0);

      // leaving SET_MIN clears seconds for one cycle
      clr();
      bus.BTN_MODE = 1'b1;
      cyc();
      chk("exit_mode", bus.Mode, 0);
      chk("exit_ncr_lo", bus.nCR_Sec, 0);
      bus.BTN_MODE = 1'b0;
      cyc();
      chk("exit_ncr_hi", bus.nCR_Sec, 1);
      chk("exit_ncr_cnt", n_ncr, 1);

      // timeout from SET_HR after 30 idle seconds
      press_mode();
      clr();
      for (int i = 1; i <= 30; i++) begin
         pulse_1hz();
         if (i == 29) chk("to_29", bus.Mode, 1);
      end
      chk("to_30", bus.Mode, 0);
      chk("to_noncr", n_ncr, 0);
      chk("to_nosec", n_sec, 0);
      chk("to_blink", bus.Blink, 1);

      // MODE edge on the timeout tick: single move to RUN
      press_mode();
      clr();
      repeat (29) pulse_1hz();
      bus.TICK_1HZ = 1'b1;
      bus.BTN_MODE = 1'b1;
      cyc();
      chk("to_mode_run", bus.Mode, 0);
      bus.TICK_1HZ = 1'b0;
      cyc();
      chk("to_mode_held", bus.Mode, 0);
      bus.BTN_MODE = 1'b0;
      cyc();
      chk("to_mode_ncr", n_ncr, 0);

      // asynchronous reset mid-SET_MIN
      press_mode();
      press_mode();
      chk("pre_rst_mode", bus.Mode, 2);
      #2;
      CR = 1'b1;
      #1;
      chk("async_mode", bus.Mode, 0);
      chk("async_ncr", bus.nCR_Sec, 1);
      bus.BTN_MODE = 1'b1;
      repeat (2) cyc();
      chk("rst_held", bus.Mode, 0);
      CR = 1'b0;
      cyc();
      chk("held_edge", bus.Mode, 1);
      bus.BTN_MODE = 1'b0;
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter RPT_DLY, default 4, meaning the number of TICK_FAST pulses INC must be held before auto-repeat starts (range 1-15).
REQ-002 The block SHALL have parameter TIMEOUT, default 30, meaning the number of TICK_1HZ pulses with no button edge before a set mode returns to RUN (range 1-63).
REQ-003 The block SHALL have parameter BLINK_DIV, default 4, meaning the number of TICK_FAST pulses per Blink half-period (range 1-15).
REQ-004 Port: CP  input  1  system clock; all state changes on the rising edge.
REQ-005 Port: CR  input  1  reset, asynchronous, active-high.
REQ-006 Port: TICK_1HZ  input  1  one-cycle pulse once per second.
REQ-007 Port: TICK_FAST  input  1  one-cycle pulse at 8 Hz; never coincident with TICK_1HZ.
REQ-008 Port: BTN_MODE  input  1  debounced mode-button level, active-high.
REQ-009 Port: BTN_INC  input  1  debounced increment-button level, active-high.
REQ-010 Port: SecMax  input  1  seconds counter currently at 59.
REQ-011 Port: MinMax  input  1  minutes counter currently at 59.
REQ-012 Port: EN_Sec  output  1  one-cycle count enable to the seconds counter.
REQ-013 Port: EN_Min  output  1  one-cycle count enable to the minutes counter.
REQ-014 Port: EN_Hr  output  1  one-cycle count enable to the 24-hour counter.
REQ-015 Port: nCR_Sec  output  1  active-low one-cycle clear to the seconds counter.
REQ-016 Port: Mode  output  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN.
REQ-017 Port: Blink  output  1  display-blank strobe for the field being set; 1 = display on.

Function
REQ-018 The FSM SHALL have states RUN, SET_HR and SET_MIN; encoding 11 SHALL be unreachable and, if entered, SHALL go to RUN on the next edge.
REQ-019 The block SHALL register BTN_MODE and BTN_INC once. A rising edge SHALL be detected in the cycle where the level is 1 and the registered copy is 0.
REQ-020 On a BTN_MODE edge the FSM SHALL advance RUN->SET_HR->SET_MIN->RUN, taking effect on the next clock edge.
REQ-021 All outputs SHALL be registered. An enable caused by an input pulse or edge sampled at edge n SHALL be high for exactly the cycle after edge n.
REQ-022 In RUN, EN_Sec SHALL follow TICK_1HZ.
REQ-023 In RUN, EN_Min SHALL follow TICK_1HZ&SecMax.
REQ-024 In RUN, EN_Hr SHALL follow TICK_1HZ&SecMax&MinMax.
REQ-025 In SET_HR, EN_Sec and EN_Min SHALL stay 0, and EN_Hr SHALL pulse on each INC edge and on each auto-repeat step.
REQ-026 In SET_MIN, EN_Sec and EN_Hr SHALL stay 0, and EN_Min SHALL pulse on each INC edge and on each auto-repeat step; no carry into hours SHALL occur.
REQ-027 Auto-repeat: a 4-bit counter SHALL clear on an INC edge and on INC low, and SHALL count TICK_FAST pulses while INC is held. Once it reaches RPT_DLY, every further TICK_FAST pulse SHALL be one step; the counter SHALL saturate.
REQ-028 Auto-repeat SHALL apply only in the set modes; in RUN, INC SHALL be ignored.
REQ-029 On the SET_MIN->RUN transition, nCR_Sec SHALL be 0 for exactly one cycle so that seconds restart from 00.
REQ-030 Timeout: a 6-bit counter SHALL clear on any button edge and on entry to a set mode, and SHALL count TICK_1HZ pulses in the set modes. On reaching TIMEOUT the FSM SHALL go to RUN, and REQ-029 SHALL apply if leaving SET_MIN.
REQ-031 Blink SHALL be 1 in RUN. In the set modes it SHALL toggle every BLINK_DIV TICK_FAST pulses, starting at 1 on mode entry, and SHALL be forced to 1 for the cycle of any INC step.
REQ-032 If MODE and INC edges coincide, the mode change SHALL win and the INC step SHALL be dropped.
REQ-033 If a BTN_MODE edge coincides with a timeout, the result SHALL be a single transition to RUN.
REQ-034 A button held through a mode change SHALL NOT generate a new edge.

Reset
REQ-035 While CR=1, Mode SHALL be 00, EN_Sec/EN_Min/EN_Hr SHALL be 0, nCR_Sec SHALL be 1 and Blink SHALL be 1.
REQ-036 While CR=1, all internal counters and the button history registers SHALL be 0.
REQ-037 Assertion of CR mid-operation SHALL abort any set mode immediately, without waiting for a clock edge.
REQ-038 After CR deassertion, a button already held high SHALL produce an edge on the first sampling edge.

Verification
REQ-039 Scenario: RUN, SecMax=1, MinMax=1, one TICK_1HZ pulse -> EN_Sec, EN_Min and EN_Hr each high for the same single cycle, one cycle after the tick.
REQ-040 Scenario: one MODE press, then 3 INC presses -> Mode=01 and exactly 3 EN_Hr pulses; EN_Sec stays 0 despite TICK_1HZ pulses.
REQ-041 Scenario: SET_MIN, INC held for 10 TICK_FAST pulses with RPT_DLY=4 -> 1 edge pulse plus 6 repeat EN_Min pulses (7 total).
REQ-042 Scenario: SET_MIN, MODE press -> Mode=00 and nCR_Sec low for 1 cycle.
REQ-043 Scenario: SET_HR with no buttons for 30 TICK_1HZ pulses -> Mode=00 after the 30th tick, with no nCR_Sec pulse.
REQ-044 Scenario: MODE and INC rising in the same cycle in SET_HR -> Mode=10 with no EN_Hr pulse. Scenario: CR pulsed mid-SET_MIN -> Mode=00 asynchronously.
